// File: rtl/gemm_stim_gen_pkg.sv
// gemm_stim_pkg: shared types and LFSR step for the GEMM operand generator
package gemm_stim_pkg;
  typedef enum logic [1:0] {MODE_LFSR, MODE_RAMP, MODE_ONES, MODE_IDENT} stim_mode_e;
  typedef enum logic [1:0] {IDLE, FILL, PRESENT, WAIT} stim_state_e;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? (s >> 1) ^ LFSR_POLY : s >> 1;
  endfunction
endpackage

// File: rtl/gemm_stim_gen_lfsr.sv
// stim_lfsr: 16-bit Galois LFSR with reseed and single-step advance, exposing its low W bits
module stim_lfsr
  import gemm_stim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001,
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] value
);
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  logic [15:0] state;
  always_ff @(posedge clk)
    if (rst || load) state <= INIT;
    else if (advance) state <= lfsr_next(state);
  always_comb value = state[W-1:0];
endmodule

// File: rtl/gemm_stim_gen.sv
// gemm_stim_gen: fills A/B/bias tiles in one of four data modes and hands them out over valid/ready
module gemm_stim_gen
  import gemm_stim_pkg::*;
#(
  parameter int M = 1,
  parameter int N = 1,
  parameter int K = 16,
  parameter int DATA_WIDTH_A = 8,
  parameter int DATA_WIDTH_B = 8,
  parameter int DATA_WIDTH_bias = DATA_WIDTH_B,
  parameter int UPDATE_PERIOD = M * DATA_WIDTH_A,
  parameter int NUM_TILES = 0,
  parameter logic [15:0] SEED_A = 16'h00A5,
  parameter logic [15:0] SEED_B = 16'h005A,
  parameter logic [15:0] SEED_bias = 16'h00C3
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [1:0]                        mode,
  output logic signed [DATA_WIDTH_A-1:0]    A_out [M][K],
  output logic signed [DATA_WIDTH_B-1:0]    B_out [K][N],
  output logic signed [DATA_WIDTH_bias-1:0] bias_out [N],
  output logic                              tile_valid,
  input  logic                              tile_ready,
  output logic [31:0]                       tile_cnt,
  output logic                              busy,
  output logic                              done,
  output logic                              gen_done
);
  localparam int A_LEN = M * K;
  localparam int B_LEN = K * N;
  localparam int AB_MAX = (A_LEN > B_LEN) ? A_LEN : B_LEN;
  localparam int FILL_LEN = (AB_MAX > N) ? AB_MAX : N;
  stim_state_e state, state_n;
  stim_mode_e mode_q;
  logic [31:0] idx, a_row, a_col, b_row, b_col, wait_cnt;
  logic accept, hs, last_tile, fill_end, wr_a, wr_b, wr_bias;
  logic [DATA_WIDTH_A-1:0] lfsr_a;
  logic [DATA_WIDTH_B-1:0] lfsr_b;
  logic [DATA_WIDTH_bias-1:0] lfsr_bias;
  logic signed [DATA_WIDTH_A-1:0] a_val;
  logic signed [DATA_WIDTH_B-1:0] b_val;
  logic signed [DATA_WIDTH_bias-1:0] bias_val;
  stim_lfsr #(.SEED(SEED_A), .W(DATA_WIDTH_A)) u_lfsr_a (
    .clk(clk), .rst(rst), .load(accept),
    .advance(wr_a && (mode_q == MODE_LFSR || mode_q == MODE_IDENT)), .value(lfsr_a));
  stim_lfsr #(.SEED(SEED_B), .W(DATA_WIDTH_B)) u_lfsr_b (
    .clk(clk), .rst(rst), .load(accept), .advance(wr_b && mode_q == MODE_LFSR), .value(lfsr_b));
  stim_lfsr #(.SEED(SEED_bias), .W(DATA_WIDTH_bias)) u_lfsr_bias (
    .clk(clk), .rst(rst), .load(accept), .advance(wr_bias && mode_q == MODE_LFSR), .value(lfsr_bias));
  always_comb begin
    accept = state == IDLE && start;
    hs = state == PRESENT && tile_ready && !abort;
    last_tile = NUM_TILES != 0 && tile_cnt == 32'(NUM_TILES - 1);
    fill_end = idx == 32'(FILL_LEN - 1);
    wr_a = state == FILL && a_row < 32'(M);
    wr_b = state == FILL && b_row < 32'(K);
    wr_bias = state == FILL && idx < 32'(N);
    tile_valid = state == PRESENT;
    busy = state != IDLE;
    a_val = (mode_q == MODE_RAMP) ? idx[DATA_WIDTH_A-1:0] :
            (mode_q == MODE_ONES) ? DATA_WIDTH_A'(1) : lfsr_a;
    b_val = (mode_q == MODE_RAMP) ? idx[DATA_WIDTH_B-1:0] :
            (mode_q == MODE_ONES) ? DATA_WIDTH_B'(1) :
            (mode_q == MODE_IDENT) ? DATA_WIDTH_B'(b_row == b_col) : lfsr_b;
    bias_val = (mode_q == MODE_RAMP) ? idx[DATA_WIDTH_bias-1:0] :
               (mode_q == MODE_LFSR) ? lfsr_bias : '0;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? FILL : IDLE;
      FILL:    state_n = fill_end ? PRESENT : FILL;
      PRESENT: state_n = !hs ? PRESENT : last_tile ? IDLE : (UPDATE_PERIOD == 0) ? FILL : WAIT;
      WAIT:    state_n = (wait_cnt == 32'(UPDATE_PERIOD - 1)) ? FILL : WAIT;
      default: state_n = IDLE;
    endcase
    // abort beats a same-cycle handshake; in IDLE a same-cycle start wins
    if (abort && state != IDLE) state_n = IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_LFSR;
      {idx, a_row, a_col, b_row, b_col, wait_cnt, tile_cnt} <= '0;
      done <= 1'b0;
      gen_done <= 1'b0;
      for (int r = 0; r < M; r++) for (int c = 0; c < K; c++) A_out[r][c] <= '0;
      for (int r = 0; r < K; r++) for (int c = 0; c < N; c++) B_out[r][c] <= '0;
      for (int c = 0; c < N; c++) bias_out[c] <= '0;
    end else begin
      if (accept) mode_q <= stim_mode_e'(mode);
      // row/col walkers restart whenever FILL is entered, so no divide is needed
      idx <= (state == FILL) ? idx + 1 : '0;
      a_col <= (state != FILL || a_col == 32'(K - 1)) ? '0 : a_col + 1;
      a_row <= (state != FILL) ? '0 : (a_col == 32'(K - 1)) ? a_row + 1 : a_row;
      b_col <= (state != FILL || b_col == 32'(N - 1)) ? '0 : b_col + 1;
      b_row <= (state != FILL) ? '0 : (b_col == 32'(N - 1)) ? b_row + 1 : b_row;
      wait_cnt <= (state == WAIT) ? wait_cnt + 1 : '0;
      tile_cnt <= accept ? '0 : (hs && tile_cnt != '1) ? tile_cnt + 1 : tile_cnt;
      done <= hs && last_tile;
      gen_done <= gen_done | (state == FILL && fill_end && !abort);
      for (int r = 0; r < M; r++) for (int c = 0; c < K; c++)
        if (wr_a && a_row == r && a_col == c) A_out[r][c] <= a_val;
      for (int r = 0; r < K; r++) for (int c = 0; c < N; c++)
        if (wr_b && b_row == r && b_col == c) B_out[r][c] <= b_val;
      for (int c = 0; c < N; c++)
        if (wr_bias && idx == c) bias_out[c] <= bias_val;
    end
  end
endmodule

// File: tb/tb_gemm_stim_gen.sv
// tb_gemm_stim_gen: directed checks of latency, data modes, handshake, abort and reset
module tb_gemm_stim_gen;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic start_a = 0, abort_a = 0, ready_a = 0;
  logic [1:0] mode_a = 0;
  logic signed [7:0] A_a [1][16];
  logic signed [7:0] B_a [16][1];
  logic signed [7:0] bias_a [1];
  logic valid_a, busy_a, done_a, gd_a;
  logic [31:0] cnt_a;
  logic start_b = 0, abort_b = 0, ready_b = 0;
  logic [1:0] mode_b = 0;
  logic signed [3:0] A_b [2][10];
  logic signed [7:0] B_b [10][2];
  logic signed [7:0] bias_b [2];
  logic valid_b, busy_b, done_b, gd_b;
  logic [31:0] cnt_b;
  gemm_stim_gen #(.NUM_TILES(3), .UPDATE_PERIOD(5)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .mode(mode_a),
    .A_out(A_a), .B_out(B_a), .bias_out(bias_a), .tile_valid(valid_a), .tile_ready(ready_a),
    .tile_cnt(cnt_a), .busy(busy_a), .done(done_a), .gen_done(gd_a));
  gemm_stim_gen #(.M(2), .N(2), .K(10), .DATA_WIDTH_A(4), .UPDATE_PERIOD(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .mode(mode_b),
    .A_out(A_b), .B_out(B_b), .bias_out(bias_b), .tile_valid(valid_b), .tile_ready(ready_b),
    .tile_cnt(cnt_b), .busy(busy_b), .done(done_b), .gen_done(gd_b));
  int vecs = 0, errs = 0;
  typedef struct { int mode; int arr; int r; int c; int exp; } vec_t;
  vec_t tbl [24];
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic start_a_wait(input string nm);
    int n = 0;
    start_a = 1;
    do begin tick(); start_a = 0; n++; end while (!valid_a && n < 100);
    chk(nm, n, 17);
  endtask
  task automatic run_b(input int m);
    int n = 0;
    abort_b = 1; tick(); abort_b = 0;
    mode_b = 2'(m); start_b = 1;
    do begin tick(); start_b = 0; n++; end while (!valid_b && n < 100);
    chk($sformatf("b latency mode%0d", m), n, 21);
  endtask
  function automatic int elem_b(input int arr, input int r, input int c);
    int s;
    if (arr == 0) return int'(A_b[r][c]);
    if (arr == 1) return int'(B_b[r][c]);
    if (arr == 2) return int'(bias_b[c]);
    s = int'(bias_b[c]);
    for (int k = 0; k < 10; k++) s += int'(A_b[r][k]) * int'(B_b[k][c]);
    return s;
  endfunction
  initial begin
    int bad, cur;
    int hs_at [3];
    int ndone, prev;
    logic signed [7:0] snap_a [16], snap_b [16];
    logic signed [7:0] snap_bias;
    // mode, arr (0 A,1 B,2 bias,3 GEMM row.col+bias), row, col, expected
    tbl[0]  = '{1, 0, 1, 5, -1};
    tbl[1]  = '{1, 0, 1, 6, 0};
    tbl[2]  = '{1, 0, 0, 8, -8};
    tbl[3]  = '{1, 0, 1, 9, 3};
    tbl[4]  = '{1, 1, 9, 1, 19};
    tbl[5]  = '{1, 1, 5, 1, 11};
    tbl[6]  = '{1, 2, 0, 1, 1};
    tbl[7]  = '{3, 1, 0, 0, 1};
    tbl[8]  = '{3, 1, 1, 1, 1};
    tbl[9]  = '{3, 1, 1, 0, 0};
    tbl[10] = '{3, 1, 9, 1, 0};
    tbl[11] = '{3, 0, 0, 0, 5};
    tbl[12] = '{3, 2, 0, 1, 0};
    tbl[13] = '{2, 0, 1, 9, 1};
    tbl[14] = '{2, 1, 4, 1, 1};
    tbl[15] = '{2, 2, 0, 0, 0};
    tbl[16] = '{2, 3, 1, 1, 10};
    tbl[17] = '{0, 0, 0, 0, 5};
    tbl[18] = '{0, 0, 0, 1, 2};
    tbl[19] = '{0, 0, 0, 2, -7};
    tbl[20] = '{0, 1, 0, 0, 90};
    tbl[21] = '{0, 1, 0, 1, 45};
    tbl[22] = '{0, 2, 0, 0, -61};
    tbl[23] = '{0, 2, 0, 1, 97};
    repeat (2) tick();
    rst = 0;
    chk("reset valid", valid_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset cnt", cnt_a, 0);
    chk("reset gen_done", gd_a, 0);
    chk("reset done", done_a, 0);
    chk("reset A", A_a[0][0], 0);
    chk("reset B_b", B_b[9][1], 0);
    // first LFSR tile: latency and seeded values
    mode_a = 0;
    start_a_wait("latency");
    chk("lfsr A00", A_a[0][0], -91);
    chk("lfsr A01", A_a[0][1], 82);
    chk("lfsr B00", B_a[0][0], 90);
    chk("lfsr B10", B_a[1][0], 45);
    chk("lfsr bias", bias_a[0], -61);
    chk("gen_done set", gd_a, 1);
    chk("busy in present", busy_a, 1);
    // tile held while consumer stalls
    for (int k = 0; k < 16; k++) begin snap_a[k] = A_a[0][k]; snap_b[k] = B_a[k][0]; end
    snap_bias = bias_a[0];
    bad = 0;
    repeat (20) begin
      tick();
      for (int k = 0; k < 16; k++) if (A_a[0][k] != snap_a[k] || B_a[k][0] != snap_b[k]) bad++;
      if (bias_a[0] != snap_bias || !valid_a) bad++;
    end
    chk("hold stable", bad, 0);
    abort_a = 1; ready_a = 1; tick(); abort_a = 0; ready_a = 0;
    chk("abort cnt", cnt_a, 0);
    chk("abort valid", valid_a, 0);
    chk("abort busy", busy_a, 0);
    chk("abort done", done_a, 0);
    // three-tile run with hold-off
    mode_a = 2; ready_a = 1; start_a = 1;
    ndone = 0; prev = 0;
    for (int k = 0; k < 3; k++) hs_at[k] = 0;
    for (int c = 1; c <= 120; c++) begin
      tick(); start_a = 0;
      if (done_a) ndone++;
      if (int'(cnt_a) != prev) begin
        if (prev < 3) hs_at[prev] = c;
        prev = int'(cnt_a);
      end
    end
    ready_a = 0;
    chk("first accept", hs_at[0], 18);
    chk("spacing 1", hs_at[1] - hs_at[0], 22);
    chk("spacing 2", hs_at[2] - hs_at[1], 22);
    chk("done pulses", ndone, 1);
    chk("run cnt", cnt_a, 3);
    chk("run busy", busy_a, 0);
    chk("ones A", A_a[0][5], 1);
    chk("ones B", B_a[7][0], 1);
    chk("ones bias", bias_a[0], 0);
    // reset in the middle of FILL, then reseeded rerun
    mode_a = 0; start_a = 1; tick(); start_a = 0;
    repeat (4) tick();
    chk("midfill A00", A_a[0][0], -91);
    rst = 1; tick(); rst = 0;
    chk("rst A00", A_a[0][0], 0);
    chk("rst gen_done", gd_a, 0);
    chk("rst busy", busy_a, 0);
    chk("rst cnt", cnt_a, 0);
    start_a_wait("relatency");
    chk("rerun A00", A_a[0][0], -91);
    chk("rerun A01", A_a[0][1], 82);
    chk("rerun gen_done", gd_a, 1);
    // data-mode table on the 2x10x2 instance
    cur = -1;
    for (int v = 0; v < 24; v++) begin
      if (tbl[v].mode != cur) begin run_b(tbl[v].mode); cur = tbl[v].mode; end
      chk($sformatf("tbl%0d m%0d arr%0d [%0d][%0d]", v, tbl[v].mode, tbl[v].arr, tbl[v].r, tbl[v].c),
          elem_b(tbl[v].arr, tbl[v].r, tbl[v].c), tbl[v].exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
